// File: rtl/mem_stage_ctl.sv
// MEM pipeline stage with integrated MEM/WB register: variable-latency data memory handshake,
// sub-word load/store lane handling and an N-channel word-only MMIO window.
module mem_stage_ctl #(
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] MMIO_BASE = 32'h1234,
  parameter int unsigned MMIO_CH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    cregwa_i,
  input  logic [1:0]              cregwd_i,
  input  logic                    regwe_i,
  input  logic [2:0]              memlen_i,
  input  logic                    memwe_i,
  input  logic [DATA_W-1:0]       rd2_i,
  input  logic [4:0]              rt_i,
  input  logic [4:0]              rd_i,
  input  logic [DATA_W-1:0]       aluout_i,
  output logic                    dm_req,
  output logic                    dm_we,
  output logic [3:0]              dm_be,
  output logic [31:0]             dm_addr,
  output logic [DATA_W-1:0]       dm_wdata,
  input  logic                    dm_gnt,
  input  logic                    dm_rvalid,
  input  logic [DATA_W-1:0]       dm_rdata,
  input  logic [32*MMIO_CH-1:0]   mmio_in,
  output logic [32*MMIO_CH-1:0]   mmio_out,
  output logic [MMIO_CH-1:0]      mmio_wstb,
  output logic                    misalign_o,
  output logic                    wb_valid_o,
  output logic                    wb_we_o,
  output logic [4:0]              wb_wa_o,
  output logic [DATA_W-1:0]       wb_wd_o
);

  localparam logic       WA_RD    = 1'b1;
  localparam logic [1:0] WD_MEMRD = 2'b01;
  localparam logic [1:0] WD_ALU   = 2'b10;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
  state_e state_q, state_d;

  logic        is_byte, is_half, is_word, is_mem, misal, in_win, is_mmio, is_dmem;
  logic [29:0] widx;
  logic [4:0]  wa_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, mmio_rd, fast_wd, ld_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic        op_we_q, op_regwe_q;
  logic [3:0]  op_be_q;
  logic [31:0] op_wdata_q, op_alu_q;
  logic [2:0]  op_len_q;
  logic [4:0]  op_wa_q;
  logic [1:0]  op_wdsel_q;

  assign ready_o = (state_q == StIdle);

  // Decode of the instruction presented by EX
  always_comb begin
    is_byte = (memlen_i == 3'b000) || (memlen_i == 3'b100);
    is_half = (memlen_i == 3'b001) || (memlen_i == 3'b101);
    is_word = !is_byte && !is_half;
    is_mem  = memwe_i || (cregwd_i == WD_MEMRD);
    misal   = is_mem && ((is_half && aluout_i[0]) || (is_word && (aluout_i[1:0] != 2'b00)));
    widx    = aluout_i[31:2] - MMIO_BASE[31:2];
    in_win  = widx < 30'(MMIO_CH);
    is_mmio = is_mem && is_word && in_win;
    is_dmem = is_mem && !is_mmio;
    wa_c    = (cregwa_i == WA_RD) ? rd_i : rt_i;
    if (is_byte) begin
      be_c    = 4'b0001 << aluout_i[1:0];
      wdata_c = {4{rd2_i[7:0]}};
    end else if (is_half) begin
      be_c    = 4'b0011 << aluout_i[1:0];
      wdata_c = {2{rd2_i[15:0]}};
    end else begin
      be_c    = 4'b1111;
      wdata_c = rd2_i;
    end
  end

  always_comb begin
    mmio_rd = '0;
    for (int c = 0; c < MMIO_CH; c++) begin
      if (widx == 30'(c)) mmio_rd = mmio_in[32*c +: 32];
    end
    if (cregwd_i == WD_ALU) fast_wd = aluout_i;
    else if (cregwd_i == WD_MEMRD && is_mmio && !misal) fast_wd = mmio_rd;
    else fast_wd = '0;
  end

  // Lane extraction for the outstanding load
  always_comb begin
    case (op_alu_q[1:0])
      2'd0:    ld_byte = dm_rdata[7:0];
      2'd1:    ld_byte = dm_rdata[15:8];
      2'd2:    ld_byte = dm_rdata[23:16];
      default: ld_byte = dm_rdata[31:24];
    endcase
    ld_half = op_alu_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_len_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = dm_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (valid_i && is_dmem && !misal) state_d = StReq;
      StReq:   if (dm_gnt) state_d = op_we_q ? StIdle : StWait;
      StWait:  if (dm_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign dm_req   = (state_q == StReq);
  assign dm_we    = dm_req & op_we_q;
  assign dm_be    = dm_req ? op_be_q : 4'b0000;
  assign dm_addr  = dm_req ? {op_alu_q[31:2], 2'b00} : 32'h0;
  assign dm_wdata = dm_req ? op_wdata_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_we_q    <= 1'b0;
      op_regwe_q <= 1'b0;
      op_be_q    <= 4'b0000;
      op_wdata_q <= '0;
      op_alu_q   <= '0;
      op_len_q   <= 3'b000;
      op_wa_q    <= 5'd0;
      op_wdsel_q <= 2'b00;
      mmio_out   <= '0;
      mmio_wstb  <= '0;
      misalign_o <= 1'b0;
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_wa_o    <= 5'd0;
      wb_wd_o    <= '0;
    end else begin
      state_q    <= state_d;
      wb_valid_o <= 1'b0;
      wb_we_o    <= 1'b0;
      misalign_o <= 1'b0;
      mmio_wstb  <= '0;
      case (state_q)
        StIdle: begin
          if (valid_i) begin
            if (misal) begin
              misalign_o <= 1'b1;
              wb_valid_o <= 1'b1;
              wb_wa_o    <= wa_c;
              wb_wd_o    <= fast_wd;
            end else if (is_dmem) begin
              op_we_q    <= memwe_i;
              op_regwe_q <= regwe_i;
              op_be_q    <= be_c;
              op_wdata_q <= wdata_c;
              op_alu_q   <= aluout_i;
              op_len_q   <= memlen_i;
              op_wa_q    <= wa_c;
              op_wdsel_q <= cregwd_i;
            end else begin
              wb_valid_o <= 1'b1;
              wb_we_o    <= regwe_i;
              wb_wa_o    <= wa_c;
              wb_wd_o    <= fast_wd;
              if (is_mmio && memwe_i) begin
                for (int c = 0; c < MMIO_CH; c++) begin
                  if (widx == 30'(c)) begin
                    mmio_out[32*c +: 32] <= rd2_i;
                    mmio_wstb[c]         <= 1'b1;
                  end
                end
              end
            end
          end
        end
        StReq: begin
          // A load's rvalid is only honoured in StWait, even if it coincides with gnt
          if (dm_gnt && op_we_q) begin
            wb_valid_o <= 1'b1;
            wb_we_o    <= op_regwe_q;
            wb_wa_o    <= op_wa_q;
            wb_wd_o    <= (op_wdsel_q == WD_ALU) ? op_alu_q : '0;
          end
        end
        StWait: begin
          if (dm_rvalid) begin
            wb_valid_o <= 1'b1;
            wb_we_o    <= op_regwe_q;
            wb_wa_o    <= op_wa_q;
            if (op_wdsel_q == WD_MEMRD) wb_wd_o <= ld_ext;
            else if (op_wdsel_q == WD_ALU) wb_wd_o <= op_alu_q;
            else wb_wd_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctl.sv
// Scoreboarded bench for mem_stage_ctl: expected writebacks are queued at issue and popped by a
// monitor on each wb_valid_o pulse; scenario tasks check handshake, MMIO and stall behaviour inline.
module tb_mem_stage_ctl;
  localparam int unsigned CH       = 4;
  localparam logic [31:0] BASE     = 32'h1234;
  localparam logic [1:0]  WD_MEMRD = 2'b01;
  localparam logic [1:0]  WD_ALU   = 2'b10;

  logic clk, rst, valid_i, ready_o, cregwa_i, regwe_i, memwe_i;
  logic [1:0] cregwd_i;
  logic [2:0] memlen_i;
  logic [31:0] rd2_i, aluout_i;
  logic [4:0] rt_i, rd_i;
  logic dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [3:0] dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [32*CH-1:0] mmio_in, mmio_out;
  logic [CH-1:0] mmio_wstb;
  logic misalign_o, wb_valid_o, wb_we_o;
  logic [4:0] wb_wa_o;
  logic [31:0] wb_wd_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [37:0] exp_q[$];
  logic [37:0] mon_exp;

  mem_stage_ctl #(.DATA_W(32), .MMIO_BASE(BASE), .MMIO_CH(CH)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .cregwa_i(cregwa_i),
    .cregwd_i(cregwd_i), .regwe_i(regwe_i), .memlen_i(memlen_i), .memwe_i(memwe_i),
    .rd2_i(rd2_i), .rt_i(rt_i), .rd_i(rd_i), .aluout_i(aluout_i), .dm_req(dm_req),
    .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .mmio_in(mmio_in), .mmio_out(mmio_out),
    .mmio_wstb(mmio_wstb), .misalign_o(misalign_o), .wb_valid_o(wb_valid_o),
    .wb_we_o(wb_we_o), .wb_wa_o(wb_wa_o), .wb_wd_o(wb_wd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  // Writeback monitor: every retire must match the oldest queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst && wb_valid_o) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL wb_unexpected: got we=%0b wa=%0d wd=%h, required no retire",
                   wb_we_o, wb_wa_o, wb_wd_o);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({wb_we_o, wb_wa_o, wb_wd_o} !== mon_exp) begin
            n_bad++;
            $display("FAIL wb_data: got we=%0b wa=%0d wd=%h, required we=%0b wa=%0d wd=%h",
                     wb_we_o, wb_wa_o, wb_wd_o, mon_exp[37], mon_exp[36:32], mon_exp[31:0]);
          end
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] wdsel, input logic regwe,
                       input logic wa_rd, input logic [2:0] len, input logic [31:0] alu,
                       input logic [31:0] d, input logic [4:0] rt, input logic [4:0] rd);
    valid_i = 1'b1; memwe_i = we; cregwd_i = wdsel; regwe_i = regwe; cregwa_i = wa_rd;
    memlen_i = len; aluout_i = alu; rd2_i = d; rt_i = rt; rd_i = rd;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b, required 1", ready_o);
    end
    n_cmp++;
    if ({dm_req, dm_we, dm_be, dm_addr, dm_wdata, misalign_o, wb_valid_o, wb_we_o, wb_wa_o,
         wb_wd_o, mmio_wstb, mmio_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got req=%b be=%h addr=%h wbv=%b wd=%h mmio=%h, required 0",
               dm_req, dm_be, dm_addr, wb_valid_o, wb_wd_o, mmio_out);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    exp_q.push_back({1'b1, 5'd3, 32'd5});
    issue(1'b0, WD_ALU, 1'b1, 1'b1, 3'b010, 32'd5, 32'd0, 5'd9, 5'd3);
    n_cmp++;
    if ({ready_o, wb_valid_o} !== 2'b11) begin
      n_bad++; $display("FAIL alu_ready: got ready=%b wbv=%b, required 1 1", ready_o, wb_valid_o);
    end
    exp_q.push_back({1'b1, 5'd17, 32'hDEADBEEF});
    issue(1'b0, WD_ALU, 1'b1, 1'b0, 3'b010, 32'hDEADBEEF, 32'd0, 5'd17, 5'd4);
    // Non-memory op whose result lands in the MMIO window must stay an ALU op
    exp_q.push_back({1'b0, 5'd8, 32'h0});
    issue(1'b0, 2'b00, 1'b0, 1'b1, 3'b010, BASE + 32'd8, 32'h77, 5'd1, 5'd8);
    n_cmp++;
    if ({mmio_wstb, dm_req, ready_o} !== 6'b000001) begin
      n_bad++;
      $display("FAIL alu_window: got wstb=%b req=%b ready=%b, required 0000 0 1",
               mmio_wstb, dm_req, ready_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (wb_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL alu_bubble: got wbv=%b, required 0", wb_valid_o);
    end
  endtask

  task automatic test_mmio();
    exp_q.push_back({1'b0, 5'd2, 32'h0});
    issue(1'b1, 2'b00, 1'b0, 1'b0, 3'b010, BASE + 32'd8, 32'hCAFEF00D, 5'd2, 5'd0);
    n_cmp++;
    if ({mmio_out[95:64], mmio_wstb, dm_req, ready_o} !== {32'hCAFEF00D, 4'b0100, 1'b0, 1'b1})
    begin
      n_bad++;
      $display("FAIL mmio_store: got ch2=%h wstb=%b req=%b ready=%b, required cafef00d 0100 0 1",
               mmio_out[95:64], mmio_wstb, dm_req, ready_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({mmio_wstb, mmio_out[95:64]} !== {4'b0000, 32'hCAFEF00D}) begin
      n_bad++;
      $display("FAIL mmio_wstb_pulse: got wstb=%b ch2=%h, required 0000 cafef00d",
               mmio_wstb, mmio_out[95:64]);
    end
    mmio_in = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001};
    exp_q.push_back({1'b1, 5'd6, 32'h44440004});
    issue(1'b0, WD_MEMRD, 1'b1, 1'b1, 3'b010, BASE + 32'd12, 32'd0, 5'd0, 5'd6);
    mmio_in = '0;
    n_cmp++;
    if ({dm_req, ready_o} !== 2'b01) begin
      n_bad++; $display("FAIL mmio_load_nostall: got req=%b ready=%b, required 0 1", dm_req, ready_o);
    end
  endtask

  task automatic do_load(input string nm, input logic [2:0] len, input logic [31:0] addr,
                         input logic [31:0] rdata, input int gk, input int rm,
                         input logic [31:0] exp_wd);
    int cyc = 0;
    int rq = 0;
    int wt = 0;
    exp_q.push_back({1'b1, 5'd10, exp_wd});
    issue(1'b0, WD_MEMRD, 1'b1, 1'b1, len, addr, 32'd0, 5'd0, 5'd10);
    while (!ready_o && cyc < 60) begin
      cyc++;
      if (dm_req) begin
        rq++;
        n_cmp++;
        if ({dm_we, dm_addr} !== {1'b0, addr[31:2], 2'b00}) begin
          n_bad++;
          $display("FAIL %s_req: got we=%b addr=%h, required 0 %h", nm, dm_we, dm_addr,
                   {addr[31:2], 2'b00});
        end
        dm_gnt = (rq == gk);
      end else begin
        wt++;
        dm_rvalid = (wt == rm);
        dm_rdata  = (wt == rm) ? rdata : 32'h0;
      end
      @(posedge clk); #1;
      dm_gnt = 1'b0; dm_rvalid = 1'b0;
    end
    n_cmp++;
    if (cyc !== gk + rm) begin
      n_bad++; $display("FAIL %s_stall: got %0d cycles, required %0d", nm, cyc, gk + rm);
    end
  endtask

  task automatic test_load();
    do_load("lb", 3'b000, 32'h103, 32'h80FFFF7F, 3, 3, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h103, 32'h80FFFF7F, 1, 1, 32'h00000080);
    do_load("lb0", 3'b000, 32'h100, 32'h80FFFF7F, 1, 2, 32'h0000007F);
    do_load("lh", 3'b001, 32'h102, 32'h80FFFF7F, 2, 1, 32'hFFFF80FF);
    do_load("lhu", 3'b101, 32'h100, 32'h80FFFF7F, 1, 1, 32'h0000FF7F);
    do_load("lw_outside", 3'b010, BASE + 32'd16, 32'h13579BDF, 1, 1, 32'h13579BDF);
  endtask

  task automatic do_store(input string nm, input logic [2:0] len, input logic [31:0] addr,
                          input logic [31:0] d, input int gk, input logic [3:0] be,
                          input logic [31:0] wd);
    int cyc = 0;
    exp_q.push_back({1'b0, 5'd11, 32'h0});
    issue(1'b1, 2'b00, 1'b0, 1'b0, len, addr, d, 5'd11, 5'd0);
    n_cmp++;
    if ({dm_req, dm_we, dm_be, dm_addr, dm_wdata} !== {1'b1, 1'b1, be, addr[31:2], 2'b00, wd})
    begin
      n_bad++;
      $display("FAIL %s_req: got req=%b we=%b be=%b addr=%h wdata=%h, required 1 1 %b %h %h",
               nm, dm_req, dm_we, dm_be, dm_addr, dm_wdata, be, {addr[31:2], 2'b00}, wd);
    end
    while (!ready_o && cyc < 60) begin
      cyc++;
      dm_gnt = (cyc == gk);
      @(posedge clk); #1;
      dm_gnt = 1'b0;
    end
    n_cmp++;
    if ({cyc, wb_valid_o} !== {gk, 1'b1}) begin
      n_bad++;
      $display("FAIL %s_retire: got %0d cycles wbv=%b, required %0d 1", nm, cyc, wb_valid_o, gk);
    end
  endtask

  task automatic test_store();
    do_store("sh", 3'b001, 32'h102, 32'h0000ABCD, 2, 4'b1100, 32'hABCDABCD);
    do_store("sb3", 3'b000, 32'h203, 32'h000000E1, 1, 4'b1000, 32'hE1E1E1E1);
    do_store("sw", 3'b010, 32'h200, 32'h01234567, 3, 4'b1111, 32'h01234567);
    // Sub-word access to the MMIO window goes to data memory instead
    do_store("sb_mmio", 3'b000, BASE + 32'd1, 32'h0000005A, 1, 4'b0010, 32'h5A5A5A5A);
    n_cmp++;
    if (mmio_out[31:0] !== 32'h0) begin
      n_bad++; $display("FAIL sb_mmio_ch0: got %h, required 0", mmio_out[31:0]);
    end
  endtask

  task automatic test_misalign();
    exp_q.push_back({1'b0, 5'd7, 32'h0});
    issue(1'b0, WD_MEMRD, 1'b1, 1'b1, 3'b010, 32'h101, 32'd0, 5'd0, 5'd7);
    n_cmp++;
    if ({misalign_o, dm_req, ready_o} !== 3'b101) begin
      n_bad++;
      $display("FAIL misalign_lw: got mis=%b req=%b ready=%b, required 1 0 1",
               misalign_o, dm_req, ready_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (misalign_o !== 1'b0) begin
      n_bad++; $display("FAIL misalign_pulse: got %b, required 0", misalign_o);
    end
    exp_q.push_back({1'b0, 5'd12, 32'h0});
    issue(1'b1, 2'b00, 1'b1, 1'b0, 3'b010, BASE + 32'd10, 32'hFFFFFFFF, 5'd12, 5'd0);
    n_cmp++;
    if ({misalign_o, mmio_wstb, mmio_out[95:64], dm_req} !== {1'b1, 4'b0000, 32'hCAFEF00D, 1'b0})
    begin
      n_bad++;
      $display("FAIL misalign_mmio: got mis=%b wstb=%b ch2=%h req=%b, required 1 0000 cafef00d 0",
               misalign_o, mmio_wstb, mmio_out[95:64], dm_req);
    end
    exp_q.push_back({1'b0, 5'd13, 32'h0});
    issue(1'b0, WD_MEMRD, 1'b1, 1'b1, 3'b101, 32'h103, 32'd0, 5'd0, 5'd13);
    n_cmp++;
    if ({misalign_o, dm_req} !== 2'b10) begin
      n_bad++; $display("FAIL misalign_lhu: got mis=%b req=%b, required 1 0", misalign_o, dm_req);
    end
  endtask

  task automatic test_async_reset();
    issue(1'b0, WD_MEMRD, 1'b1, 1'b1, 3'b010, 32'h300, 32'd0, 5'd0, 5'd14);
    dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    n_cmp++;
    if ({ready_o, dm_req} !== 2'b00) begin
      n_bad++; $display("FAIL rst_wait_state: got ready=%b req=%b, required 0 0", ready_o, dm_req);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({ready_o, dm_req, wb_valid_o, mmio_out} !== {1'b1, 1'b0, 1'b0, 128'h0}) begin
      n_bad++;
      $display("FAIL rst_async: got ready=%b req=%b wbv=%b mmio=%h, required 1 0 0 0",
               ready_o, dm_req, wb_valid_o, mmio_out);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    dm_rvalid = 1'b1; dm_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    n_cmp++;
    if ({wb_valid_o, ready_o, dm_req} !== 3'b010) begin
      n_bad++;
      $display("FAIL rst_late_rvalid: got wbv=%b ready=%b req=%b, required 0 1 0",
               wb_valid_o, ready_o, dm_req);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; valid_i = 1'b0; cregwa_i = 1'b0; cregwd_i = 2'b00; regwe_i = 1'b0;
    memlen_i = 3'b000; memwe_i = 1'b0; rd2_i = '0; rt_i = '0; rd_i = '0; aluout_i = '0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0; mmio_in = '0;
    test_reset();
    test_alu();
    test_mmio();
    test_load();
    test_store();
    test_misalign();
    test_async_reset();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
